// File: rtl/rr_mux3_pkg.sv
// Shared types and select codes for the 3-way round-robin mux arbiter.
package rr_mux3_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_C    = 2'b10;
  localparam logic [1:0] SEL_IDLE = 2'b11;

  // Next requester code after c wraps back to a.
  function automatic logic [1:0] next_code(input logic [1:0] code);
    return (code == SEL_C) ? SEL_A : code + 2'd1;
  endfunction

endpackage

// File: rtl/rr_mux3_arbiter_pick.sv
// Combinational 3-way round-robin picker: first set request starting at ptr.
module rr_pick3
  import rr_mux3_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] grant,
  output logic       any
);

  always_comb begin
    grant = SEL_IDLE;
    any   = |req;
    case (ptr)
      2'd1: begin
        if      (req[1]) grant = SEL_B;
        else if (req[2]) grant = SEL_C;
        else if (req[0]) grant = SEL_A;
      end
      2'd2: begin
        if      (req[2]) grant = SEL_C;
        else if (req[0]) grant = SEL_A;
        else if (req[1]) grant = SEL_B;
      end
      default: begin
        if      (req[0]) grant = SEL_A;
        else if (req[1]) grant = SEL_B;
        else if (req[2]) grant = SEL_C;
      end
    endcase
  end

endmodule

// File: rtl/rr_mux3_arbiter.sv
// Round-robin burst arbiter driving a shared 3:1 mux into a one-entry output slot.
module rr_mux3_arbiter
  import rr_mux3_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       req_valid,
  output logic [2:0]       req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int HW = $clog2(HOLD_MAX) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

  state_t          state;
  logic [1:0]      owner;
  logic [1:0]      ptr;
  logic [HW-1:0]   hold_cnt;
  logic [1:0]      pick;
  logic            pick_any;
  logic            slot_free;
  logic            accept;
  logic            other_pend;
  logic [WIDTH-1:0] sel_data;

  rr_pick3 u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick),
    .any   (pick_any)
  );

  assign sel       = (state == BUSY) ? owner : SEL_IDLE;
  assign slot_free = !out_valid || out_ready;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    req_ready = '0;
    if (state == BUSY && slot_free) req_ready[owner] = 1'b1;
  end

  always_comb begin
    other_pend = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (2'(i) != owner) other_pend = other_pend | req_valid[i];
    end
  end

  // Idle code holds the current slot contents so the mux has a single default arm.
  always_comb begin
    case (sel)
      SEL_A:   sel_data = a;
      SEL_B:   sel_data = b;
      SEL_C:   sel_data = c;
      default: sel_data = out;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= SEL_A;
      ptr      <= SEL_A;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state    <= BUSY;
            owner    <= pick;
            hold_cnt <= '0;
          end
        end
        BUSY: begin
          if (!req_valid[owner]) begin
            state <= IDLE;
            ptr   <= next_code(owner);
          end else if (accept) begin
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt <= '0;
              if (other_pend) begin
                state <= IDLE;
                ptr   <= next_code(owner);
              end
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      out       <= sel_data;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/rr_mux3_arbiter.md
# rr_mux3_arbiter

Round-robin controller that shares a single 3:1 select-mux datapath between three valid/ready requesters (a, b, c) and drives the mux select code. Grants are held for bursts of up to HOLD_MAX beats, and the selected data passes through a one-entry registered output slot with its own valid/ready handshake. The block sits in front of any consumer that previously took a raw `sel`-driven mux. It guarantees exactly one idle/default select code and never selects more than one source per cycle.

## Interface
- WIDTH, 3, data width of each source and of `out`
- HOLD_MAX, 4, max consecutive accepted beats per grant while another requester is pending (>=1)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  3  bit0=a, bit1=b, bit2=c request valid
- req_ready  out  3  per-requester accept, combinational
- a, b, c  in  WIDTH  source data
- sel  out  2  grant code: 00=a, 01=b, 10=c, 11=idle (only idle code)
- out  out  WIDTH  registered selected data
- out_valid  out  1  `out` holds an unconsumed beat
- out_ready  in  1  consumer accepts `out`

## Operation
- Reset values:
  - FSM is IDLE.
  - `sel`=11, `out`=0, `out_valid`=0, `req_ready`=000.
  - Priority pointer ptr=0 (a first); hold_cnt=0.
- slot_free = !out_valid || out_ready.
- req_ready[i] = (state==BUSY) && (owner==i) && slot_free; all other bits are 0.
- Beat accepted on req_valid[i] && req_ready[i]:
  - `out` <= selected source;
  - `out_valid` <= 1.
- Otherwise, if out_valid && out_ready, then `out_valid` <= 0.
- `out` holds its last value when not valid.
- FSM states:
  - IDLE:
    - `sel`=11.
    - If any req_valid, owner = first valid requester searching ptr, ptr+1, ptr+2 (mod 3).
    - Go to BUSY with hold_cnt=0.
    - Otherwise stay in IDLE.
  - BUSY:
    - `sel`=owner.
    - Each accepted beat increments hold_cnt.
    - Release, i.e. go to IDLE next cycle with ptr <= owner+1 mod 3, when either:
      - (a) req_valid[owner]==0 this cycle, or
      - (b) a beat is accepted with hold_cnt==HOLD_MAX-1 and any other req_valid bit is set.
    - In case (b) with no other requester pending: keep the grant and set hold_cnt <= 0.
- Backpressure (slot not free) stalls the BUSY state. The grant, hold_cnt and `sel` are unchanged while stalled.
- A requester dropping valid while stalled triggers release rule (a).
- hold_cnt width is clog2(HOLD_MAX)+1. It never wraps past HOLD_MAX-1.

## Timing
- Grant latency: req_valid first high in IDLE at cycle t gives `sel`=owner and a possible req_ready at t+1.
- Data latency: a beat accepted at cycle t appears on `out`/`out_valid` at t+1.
- Full throughput: one beat per cycle within a grant while out_ready=1.
- Handover costs exactly one IDLE cycle (`sel`=11) between grants.
- Simultaneous drain and accept in one cycle: allowed; `out_valid` stays 1 with the new data.
- rst_n low at any time, including mid-burst or with `out_valid`=1: immediately returns all state to reset values. The pending beat is dropped. Release of reset is synchronized by the integrator.

## Structure
- Shared package `rr_mux3_pkg` contains:
  - state typedef (IDLE, BUSY);
  - constants SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_IDLE=2'b11.
- Sub-module `rr_pick3`: combinational 3-way round-robin picker.
  - Inputs: req[2:0], ptr[1:0].
  - Outputs: grant code, any.
  - Instantiated once in IDLE decode.
- Datapath mux is a single case on `sel` with one default arm (idle → hold).

## Test plan
- Reset/idle: hold rst_n=0 for 3 cycles, then release with req_valid=000 → `sel`=11, `out_valid`=0, `out`=0, `req_ready`=000 for 10 cycles.
- Single requester: b valid for 6 beats with data 1..6, out_ready=1, HOLD_MAX=4 → `sel`=01 from cycle 1. Six consecutive accepts with no bubble; `out` shows 1..6 on cycles 2..7.
- Fairness: all req_valid=111 continuously, out_ready=1 → four beats each in the order a, b, c, a…, with one `sel`=11 cycle between grants.
- Backpressure: hold out_ready=0 while `out_valid`=1 (`out`=5) for 4 cycles → `req_ready`=000 and `out`=5 stable. Then out_ready=1 → the next beat is accepted the same cycle.
- Early release: a granted; a drops valid after 2 beats while c is valid → next cycle IDLE, then c granted (ptr=1, b not pending, so c wins).
- Reset mid-burst: pull rst_n low while `sel`=10 and `out_valid`=1 → all outputs at reset values that cycle; after release, a wins first arbitration.
